decimal_entry: RTL

DECIMAL_ENTRY -- requirements
Module: decimal_entry

---
 rtl/decimal_entry_pkg.sv | 26 ++
 rtl/decimal_entry_key_edge.sv | 28 ++
 rtl/decimal_entry.sv | 123 ++++++++++++
 3 files changed

// File: rtl/decimal_entry_pkg.sv
// rtl/decimal_entry_pkg.sv - shared types, constants and limit helpers for decimal_entry
package decimal_entry_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTRY = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   localparam int DIGIT_MAX = 9;
   localparam int ACC_W     = 14;

   function automatic logic [ACC_W-1:0] unsigned_limit(input int width);
      return ACC_W'((1 << width) - 1);
   endfunction

   function automatic logic [ACC_W-1:0] pos_limit(input int width);
      return ACC_W'((1 << (width - 1)) - 1);
   endfunction

   function automatic logic [ACC_W-1:0] neg_limit(input int width);
      return ACC_W'(1 << (width - 1));
   endfunction

endpackage

// File: rtl/decimal_entry_key_edge.sv
// rtl/decimal_entry_key_edge.sv - key_edge: 2-flop synchronizer plus falling-edge detector
module key_edge (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Reset to the released level so a key held through reset is not seen at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign press = prev_q & ~sync2_q;

endmodule

// File: rtl/decimal_entry.sv
// rtl/decimal_entry.sv - keypad decimal entry FSM; DECIMAL_ENTRY_SIGNED_EN enables the sign key
module decimal_entry
   import decimal_entry_pkg::*;
#(
   parameter int WIDTH      = 10,
   parameter int MAX_DIGITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       digit_i,
   input  logic             digit_key_n,
   input  logic             enter_key_n,
   input  logic             clr_key_n,
   input  logic             neg_key_n,
   output logic [ACC_W-1:0] acc_o,
   output logic [2:0]       digit_cnt_o,
   output logic             neg_o,
   output logic [WIDTH-1:0] value_o,
   output logic             value_valid_o,
   output logic             ovf_o
);

`ifdef DECIMAL_ENTRY_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic dig_ev, ent_ev, clr_ev, neg_ev;

   key_edge u_digit (.clk(clk), .rst(rst), .key_n(digit_key_n), .press(dig_ev));
   key_edge u_enter (.clk(clk), .rst(rst), .key_n(enter_key_n), .press(ent_ev));
   key_edge u_clr   (.clk(clk), .rst(rst), .key_n(clr_key_n),   .press(clr_ev));
   key_edge u_neg   (.clk(clk), .rst(rst), .key_n(neg_key_n),   .press(neg_ev));

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [2:0]         cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   value_q, value_d;
   logic               valid_q, valid_d;

   logic [ACC_W-1:0]   limit;
   logic [ACC_W-1:0]   acc_twos;
   logic               digit_ok;

   assign limit    = !SIGNED_EN ? unsigned_limit(WIDTH) :
                     (neg_q ? neg_limit(WIDTH) : pos_limit(WIDTH));
   assign acc_twos = neg_q ? (~acc_q + 1'b1) : acc_q;
   assign digit_ok = (digit_i <= 4'(DIGIT_MAX));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         value_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         value_q <= value_d;
         valid_q <= valid_d;
      end
   end

   // One event per cycle at most; lower-priority events in the same cycle are dropped.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      value_d = value_q;
      valid_d = 1'b0;
      if (clr_ev) begin
         state_d = ST_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         neg_d   = 1'b0;
      end else if (ent_ev) begin
         if (state_q == ST_ENTRY) begin
            if (acc_q <= limit) begin
               value_d = acc_twos[WIDTH-1:0];
               valid_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_ERROR;
            end
         end
      end else if (neg_ev && SIGNED_EN) begin
         if (state_q == ST_IDLE || state_q == ST_ENTRY) begin
            neg_d = ~neg_q;
         end
      end else if (dig_ev && digit_ok) begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               acc_d   = ACC_W'(digit_i);
               cnt_d   = 3'd1;
               neg_d   = 1'b0;
               state_d = ST_ENTRY;
            end
            ST_ENTRY: begin
               if (cnt_q < 3'(MAX_DIGITS)) begin
                  acc_d = acc_q * ACC_W'(10) + ACC_W'(digit_i);
                  cnt_d = cnt_q + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign acc_o         = acc_q;
   assign digit_cnt_o   = cnt_q;
   assign neg_o         = SIGNED_EN ? neg_q : 1'b0;
   assign value_o       = value_q;
   assign value_valid_o = valid_q;
   assign ovf_o         = (state_q == ST_ERROR);

endmodule
